io_port_responder: RTL and testbench

IO_PORT_RESPONDER -- requirements
Module: io_port_responder

---
 rtl/io_pkg.sv | 15 +
 rtl/io_fifo.sv | 68 ++++++
 rtl/io_port_responder.sv | 169 ++++++++++++++++
 tb/tb_io_port_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared constants and input-handshake state encoding for the IO port responder.
package io_pkg;

    localparam int unsigned DEFAULT_DATA_W     = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned COUNT_W            = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RELEASE = 2'd3
    } in_state_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is honoured only when a pop happens the same cycle.
module io_fifo
    import io_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned WIDTH = DEFAULT_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_push_data,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_head,
    output logic [COUNT_W-1:0] o_count,
    output logic               o_full,
    output logic               o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [COUNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == COUNT_W'(DEPTH));
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + COUNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - COUNT_W'(1);
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/io_port_responder.sv
// Processor IO port: buffered switch input with 4-phase read handshake and a latched display output.
// Optional macro IO_ENTER_SYNC_EN: synchronise sw_enter and push once per press.
module io_port_responder
    import io_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_req,
    output logic               in_ready,
    output logic [DATA_W-1:0]  in_data,
    input  logic               new_out,
    input  logic [DATA_W-1:0]  out_data,
    output logic               out_done,
    input  logic [DATA_W-1:0]  sw_data,
    input  logic               sw_enter,
    output logic [DATA_W-1:0]  disp_data,
    output logic [COUNT_W-1:0] fifo_count,
    output logic               overflow,
    output logic [1:0]         state
);

    in_state_t          r_state;
    logic               r_in_ready;
    logic [DATA_W-1:0]  r_in_data;
    logic               r_in_armed;
    logic               r_out_done;
    logic               r_out_armed;
    logic [DATA_W-1:0]  r_disp_data;
    logic               r_overflow;

    logic               w_enter;
    logic               w_pop;
    logic [DATA_W-1:0]  w_head;
    logic [COUNT_W-1:0] w_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;

`ifdef IO_ENTER_SYNC_EN
    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Two-flop synchroniser plus one history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sw_enter;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_enter = r_sync2 & ~r_sync3;
`else
    assign w_enter = sw_enter;
`endif

    io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_enter),
        .i_push_data (sw_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // A word is taken on a fresh request in IDLE or while a request is still pending in WAIT.
    assign w_pop = ~w_fifo_empty & in_req &
                   (((r_state == ST_IDLE) & r_in_armed) | (r_state == ST_WAIT));

    // Input handshake; r_in_armed forces in_req to be seen low before a new request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_in_data  <= '0;
            r_in_armed <= 1'b0;
        end else begin
            if (!in_req) begin
                r_in_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (in_req && r_in_armed) begin
                        r_in_armed <= 1'b0;
                        if (w_pop) begin
                            r_in_data  <= w_head;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_ACK;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!in_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_pop) begin
                        r_in_data  <= w_head;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!in_req) begin
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output handshake runs independently of the input side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_done  <= 1'b0;
            r_out_armed <= 1'b0;
            r_disp_data <= '0;
        end else begin
            if (!new_out) begin
                r_out_armed <= 1'b1;
            end
            if (new_out && !r_out_done && r_out_armed) begin
                r_disp_data <= out_data;
                r_out_done  <= 1'b1;
                r_out_armed <= 1'b0;
            end else if (r_out_done && !new_out) begin
                r_out_done <= 1'b0;
            end
        end
    end

    // Sticky: an enter was lost because the FIFO was full and nothing left it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_enter && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign in_ready   = r_in_ready;
    assign in_data    = r_in_data;
    assign out_done   = r_out_done;
    assign disp_data  = r_disp_data;
    assign fifo_count = w_count;
    assign overflow   = r_overflow;
    assign state      = r_state;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed plus randomised bench for io_port_responder against a queue-based reference model.
module tb_io_port_responder;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_req;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          new_out;
    logic [DW-1:0] out_data;
    logic          out_done;
    logic [DW-1:0] sw_data;
    logic          sw_enter;
    logic [DW-1:0] disp_data;
    logic [4:0]    fifo_count;
    logic          overflow;
    logic [1:0]    state;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mq[$];
    bit            m_ovf;
    logic [DW-1:0] m_disp;

    io_port_responder #(.FIFO_DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_req     (in_req),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .new_out    (new_out),
        .out_data   (out_data),
        .out_done   (out_done),
        .sw_data    (sw_data),
        .sw_enter   (sw_enter),
        .disp_data  (disp_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One enter event carrying d; returns on a negedge after the push edge.
    task automatic do_enter(input logic [DW-1:0] d);
        sw_data  = d;
        sw_enter = 1'b1;
`ifdef IO_ENTER_SYNC_EN
        repeat (3) @(negedge clk);
        sw_enter = 1'b0;
        repeat (3) @(negedge clk);
`else
        @(negedge clk);
        sw_enter = 1'b0;
`endif
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
    endtask

    // Full read handshake; checks data against the model queue head.
    task automatic read_word(input string tag);
        logic [DW-1:0] exp;
        int            lat;
        exp    = (mq.size() > 0) ? mq.pop_front() : 'x;
        in_req = 1'b1;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!in_ready && lat < 20);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_lat"},   32'(lat),      32'd1);
        chk({tag, "_data"},  in_data,       exp);
        chk({tag, "_ack"},   32'(state),    32'd2);
        in_req = 1'b0;
        @(negedge clk);
        chk({tag, "_rel_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_rel_st"},  32'(state),    32'd3);
        @(negedge clk);
        chk({tag, "_idle"},    32'(state),    32'd0);
    endtask

    task automatic write_word(input string tag, input logic [DW-1:0] d);
        chk({tag, "_pre"}, 32'(out_done), 32'd0);
        new_out  = 1'b1;
        out_data = d;
        @(negedge clk);
        m_disp = d;
        chk({tag, "_done"}, 32'(out_done), 32'd1);
        chk({tag, "_disp"}, disp_data,     m_disp);
        out_data = ~d;
        @(negedge clk);
        chk({tag, "_hold"}, 32'(out_done), 32'd1);
        chk({tag, "_stable"}, disp_data,   m_disp);
        new_out = 1'b0;
        @(negedge clk);
        chk({tag, "_clr"}, 32'(out_done), 32'd0);
    endtask

    initial begin
        int            op;
        int            lat;
        logic [DW-1:0] d;

        rst = 1'b1; in_req = 1'b0; new_out = 1'b0; out_data = '0;
        sw_data = '0; sw_enter = 1'b0; m_ovf = 1'b0; m_disp = '0;
        #2;
        chk("rst_ready", 32'(in_ready),   32'd0);
        chk("rst_done",  32'(out_done),   32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf",   32'(overflow),   32'd0);
        chk("rst_state", 32'(state),      32'd0);
        chk("rst_indata", in_data,        32'd0);
        chk("rst_disp",  disp_data,       32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic read of one entered word.
        do_enter(32'h0000_00AA);
        chk("aa_count", 32'(fifo_count), 32'd1);
        read_word("aa");

        // Request on an empty FIFO parks in WAIT until a word arrives.
        in_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("wait_state", 32'(state),    32'd1);
        chk("wait_ready", 32'(in_ready), 32'd0);
        do_enter(32'h0000_1234);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("wait_got",  32'(in_ready), 32'd1);
        chk("wait_data", in_data,       mq.pop_front());
        in_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("wait_idle", 32'(state), 32'd0);

        // Overflow on the fifth enter; reads return the first four.
        for (int i = 1; i <= 5; i++) do_enter(DW'(i));
        chk("ovf_count", 32'(fifo_count), 32'(DEPTH));
        chk("ovf_flag",  32'(overflow),   32'(m_ovf));
        for (int i = 1; i <= 4; i++) read_word("ovf_rd");
        chk("ovf_empty", 32'(fifo_count), 32'd0);
        chk("ovf_sticky", 32'(overflow),  32'd1);

        write_word("out", 32'hDEAD_BEEF);

        // Both handshakes started on the same edge.
        do_enter(32'h0000_5555);
        in_req = 1'b1; new_out = 1'b1; out_data = 32'hCAFE_F00D;
        @(negedge clk);
        chk("cc_ready", 32'(in_ready), 32'd1);
        chk("cc_data",  in_data,       mq.pop_front());
        chk("cc_done",  32'(out_done), 32'd1);
        chk("cc_disp",  disp_data,     32'hCAFE_F00D);
        m_disp = 32'hCAFE_F00D;
        in_req = 1'b0; new_out = 1'b0;
        repeat (2) @(negedge clk);
        chk("cc_idle", 32'(state),    32'd0);
        chk("cc_clr",  32'(out_done), 32'd0);

        // Reset in the middle of an ACK with two words still buffered.
        do_enter(32'h11); do_enter(32'h22); do_enter(32'h33);
        in_req = 1'b1;
        @(negedge clk);
        chk("mr_ack",   32'(state),      32'd2);
        chk("mr_count", 32'(fifo_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mr_ready", 32'(in_ready),   32'd0);
        chk("mr_cnt0",  32'(fifo_count), 32'd0);
        chk("mr_ovf0",  32'(overflow),   32'd0);
        chk("mr_st0",   32'(state),      32'd0);
        mq.delete(); m_ovf = 1'b0; m_disp = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mr_noreq", 32'(state),    32'd0);
        chk("mr_nordy", 32'(in_ready), 32'd0);
        in_req = 1'b0;
        @(negedge clk);

        // Held enter: one push when synchronised, one per cycle otherwise.
        sw_data = 32'h77; sw_enter = 1'b1;
`ifdef IO_ENTER_SYNC_EN
        @(negedge clk); chk("hold_e1", 32'(fifo_count), 32'd0);
        @(negedge clk); chk("hold_e2", 32'(fifo_count), 32'd0);
        @(negedge clk); chk("hold_e3", 32'(fifo_count), 32'd1);
        repeat (17) @(negedge clk);
        chk("hold_e20", 32'(fifo_count), 32'd1);
        sw_enter = 1'b0;
        repeat (3) @(negedge clk);
        mq.push_back(32'h77);
`else
        @(negedge clk); chk("hold_e1", 32'(fifo_count), 32'd1);
        @(negedge clk); chk("hold_e2", 32'(fifo_count), 32'd2);
        @(negedge clk); chk("hold_e3", 32'(fifo_count), 32'd3);
        sw_enter = 1'b0;
        repeat (3) mq.push_back(32'h77);
        @(negedge clk);
`endif
        while (mq.size() > 0) read_word("hold_rd");
        chk("hold_ovf", 32'(overflow), 32'd0);

        // Randomised mix checked against the queue model.
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            case (op)
                0, 1: begin
                    d = $urandom;
                    do_enter(d);
                    chk("r_count", 32'(fifo_count), 32'(mq.size()));
                    chk("r_ovf",   32'(overflow),   32'(m_ovf));
                end
                2: begin
                    if (mq.size() > 0) begin
                        read_word("r_rd");
                    end else begin
                        in_req = 1'b1;
                        repeat (3) @(negedge clk);
                        chk("r_wait", 32'(state), 32'd1);
                        in_req = 1'b0;
                        @(negedge clk);
                        chk("r_wait_idle", 32'(state), 32'd0);
                    end
                end
                default: write_word("r_out", $urandom);
            endcase
        end
        while (mq.size() > 0) read_word("r_drain");
        chk("end_count", 32'(fifo_count), 32'd0);
        chk("end_disp",  disp_data,       m_disp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
